// File: rtl/b_pkg.sv
// Shared types and constants for the perceptron branch resolve/train block.
// Holds the pending-entry layout, the training FSM states and the weight step.
package b_pkg;

    localparam int HIST_LEN    = 8;
    localparam int WEIGHT_W    = 8;
    localparam int TABLE_DEPTH = 228;
    localparam int QUEUE_DEPTH = 8;
    localparam int IDX_W       = 8;
    localparam int QPTR_W      = $clog2(QUEUE_DEPTH);
    localparam int QCNT_W      = QPTR_W + 1;
    localparam int ROW_W       = (HIST_LEN + 1) * WEIGHT_W;

    localparam logic [QCNT_W-1:0] Q_FULL = QCNT_W'(QUEUE_DEPTH);

    localparam logic signed [WEIGHT_W-1:0] WEIGHT_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] WEIGHT_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic signed [WEIGHT_W-1:0] WEIGHT_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CALC,
        WR
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0]    index;
        logic [HIST_LEN-1:0] hist;
        logic                taken;
        logic [31:0]         target;
        logic [31:0]         fallthrough;
    } pend_entry_t;

    // Moves a weight one step toward the requested direction, pinned at the rails.
    function automatic logic signed [WEIGHT_W-1:0] sat_step(
        input logic signed [WEIGHT_W-1:0] w,
        input logic                       up
    );
        if (up) begin
            return (w == WEIGHT_MAX) ? w : w + WEIGHT_ONE;
        end
        return (w == WEIGHT_MIN) ? w : w - WEIGHT_ONE;
    endfunction

endpackage

// File: rtl/b_pending_queue.sv
// In-order FIFO of outstanding B predictions with push, pop, clear and occupancy.
// Clear wins over a same-cycle push or pop so a mispredict empties it completely.
module b_pending_queue
    import b_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  pend_entry_t       i_push_data,
    input  logic              i_pop,
    input  logic              i_clear,
    output pend_entry_t       o_head,
    output logic [QCNT_W-1:0] o_count
);

    logic [QPTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [QPTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [QCNT_W-1:0] count_q, count_d;
    pend_entry_t       mem_q [QUEUE_DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + QCNT_W'(i_push) - QCNT_W'(i_pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) mem_q[wr_ptr_q] <= i_push_data;
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/b_resolve_train.sv
// Retires queued B predictions against resolved outcomes, flushes on mispredict,
// and runs the read-modify-write perceptron update on direction mispredicts.
module b_resolve_train
    import b_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enqValid,
    input  logic [IDX_W-1:0]    i_enqIndex_8,
    input  logic [HIST_LEN-1:0] i_enqHist_8,
    input  logic                i_enqTaken,
    input  logic [31:0]         i_enqTarget_32,
    input  logic [31:0]         i_enqFallthrough_32,
    output logic                o_enqReady,
    input  logic                i_resValid,
    input  logic                i_resTaken,
    input  logic [31:0]         i_resTarget_32,
    output logic                o_resReady,
    output logic                o_flush,
    output logic [31:0]         o_correctPC_32,
    output logic [QCNT_W-1:0]   o_pendingCount_4,
    output logic                o_wtRdEn,
    output logic [IDX_W-1:0]    o_wtRdIdx_8,
    input  logic [ROW_W-1:0]    i_wtRdData_72,
    output logic                o_wtWrEn,
    output logic [IDX_W-1:0]    o_wtWrIdx_8,
    output logic [ROW_W-1:0]    o_wtWrData_72
);

    state_e              state_q, state_d;
    logic                alive_q, alive_d;
    logic                flush_q, flush_d;
    logic [31:0]         correct_pc_q, correct_pc_d;
    logic [IDX_W-1:0]    tr_idx_q, tr_idx_d;
    logic [HIST_LEN-1:0] tr_hist_q, tr_hist_d;
    logic                tr_actual_q, tr_actual_d;
    logic [ROW_W-1:0]    row_q, row_d;

    pend_entry_t       head;
    pend_entry_t       enq_entry;
    logic [QCNT_W-1:0] count;
    logic              enq_ready, res_ready, enq_fire, res_fire;
    logic              dir_miss, tgt_miss, mispredict;

    // Readies depend only on registered state; alive_q holds them low straight out of reset.
    assign enq_ready  = alive_q && (count != Q_FULL) && !flush_q;
    assign res_ready  = (count != '0) && (state_q == IDLE);
    assign enq_fire   = i_enqValid && enq_ready;
    assign res_fire   = i_resValid && res_ready;
    assign dir_miss   = res_fire && (head.taken != i_resTaken);
    assign tgt_miss   = res_fire && head.taken && i_resTaken && (head.target != i_resTarget_32);
    assign mispredict = dir_miss || tgt_miss;

    assign enq_entry = '{
        index:       i_enqIndex_8,
        hist:        i_enqHist_8,
        taken:       i_enqTaken,
        target:      i_enqTarget_32,
        fallthrough: i_enqFallthrough_32
    };

    b_pending_queue u_queue (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (enq_fire),
        .i_push_data (enq_entry),
        .i_pop       (res_fire),
        .i_clear     (mispredict),
        .o_head      (head),
        .o_count     (count)
    );

    always_comb begin
        alive_d      = 1'b1;
        flush_d      = mispredict;
        correct_pc_d = '0;
        if (mispredict) correct_pc_d = i_resTaken ? i_resTarget_32 : head.fallthrough;
        tr_idx_d     = tr_idx_q;
        tr_hist_d    = tr_hist_q;
        tr_actual_d  = tr_actual_q;
        if (dir_miss) begin
            tr_idx_d    = head.index;
            tr_hist_d   = head.hist;
            tr_actual_d = i_resTaken;
        end
        row_d = row_q;
        if (state_q == CALC) begin
            for (int j = 0; j < HIST_LEN; j++) begin
                row_d[j*WEIGHT_W +: WEIGHT_W] =
                    sat_step($signed(i_wtRdData_72[j*WEIGHT_W +: WEIGHT_W]), tr_hist_q[j] == tr_actual_q);
            end
            row_d[HIST_LEN*WEIGHT_W +: WEIGHT_W] =
                sat_step($signed(i_wtRdData_72[HIST_LEN*WEIGHT_W +: WEIGHT_W]), tr_actual_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            alive_q      <= 1'b0;
            flush_q      <= 1'b0;
            correct_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            alive_q      <= alive_d;
            flush_q      <= flush_d;
            correct_pc_q <= correct_pc_d;
        end
    end

    always_ff @(posedge i_clk) begin
        tr_idx_q    <= tr_idx_d;
        tr_hist_q   <= tr_hist_d;
        tr_actual_q <= tr_actual_d;
        row_q       <= row_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dir_miss) state_d = RD;
            RD:      state_d = CALC;
            CALC:    state_d = WR;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_enqReady       = enq_ready;
        o_resReady       = res_ready;
        o_flush          = flush_q;
        o_correctPC_32   = correct_pc_q;
        o_pendingCount_4 = count;
        o_wtRdEn         = (state_q == RD);
        o_wtRdIdx_8      = (state_q == RD) ? tr_idx_q : '0;
        o_wtWrEn         = (state_q == WR);
        o_wtWrIdx_8      = (state_q == WR) ? tr_idx_q : '0;
        o_wtWrData_72    = (state_q == WR) ? row_q : '0;
    end

endmodule

// File: tb/tb_b_resolve_train.sv
// Self-checking bench for b_resolve_train: directed scenarios then random traffic,
// compared cycle by cycle against a queue-based reference model of the resolve/train rules.
module tb_b_resolve_train;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enq_valid, enq_taken, res_valid, res_taken;
    logic [7:0]  enq_index, enq_hist;
    logic [31:0] enq_target, enq_fall, res_target;
    logic        enq_ready, res_ready, flush, wt_rd_en, wt_wr_en;
    logic [31:0] correct_pc;
    logic [3:0]  pending_count;
    logic [7:0]  wt_rd_idx, wt_wr_idx;
    logic [71:0] wt_rd_data, wt_wr_data;

    always #5 clk = ~clk;

    b_resolve_train dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_enqValid          (enq_valid),
        .i_enqIndex_8        (enq_index),
        .i_enqHist_8         (enq_hist),
        .i_enqTaken          (enq_taken),
        .i_enqTarget_32      (enq_target),
        .i_enqFallthrough_32 (enq_fall),
        .o_enqReady          (enq_ready),
        .i_resValid          (res_valid),
        .i_resTaken          (res_taken),
        .i_resTarget_32      (res_target),
        .o_resReady          (res_ready),
        .o_flush             (flush),
        .o_correctPC_32      (correct_pc),
        .o_pendingCount_4    (pending_count),
        .o_wtRdEn            (wt_rd_en),
        .o_wtRdIdx_8         (wt_rd_idx),
        .i_wtRdData_72       (wt_rd_data),
        .o_wtWrEn            (wt_wr_en),
        .o_wtWrIdx_8         (wt_wr_idx),
        .o_wtWrData_72       (wt_wr_data)
    );

    typedef struct {
        logic [7:0]  idx;
        logic [7:0]  hist;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;

    ent_t        mq[$];
    logic [71:0] ref_tab [256];
    logic [71:0] env_mem [256];
    bit          m_alive, m_flush;
    logic [31:0] m_pc;
    int          m_phase;
    logic [7:0]  m_tr_idx;
    logic [71:0] m_row;
    int          n_checks = 0;
    int          n_errors = 0;

    // Weight table environment: one-cycle read latency, loaded from the reference table under reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= ref_tab[i];
        end else begin
            if (wt_rd_en) wt_rd_data <= env_mem[wt_rd_idx];
            if (wt_wr_en) env_mem[wt_wr_idx] <= wt_wr_data;
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] train_row(input logic [71:0] row, input logic [7:0] hist, input logic act);
        logic [71:0] r;
        int          w;
        r = row;
        for (int j = 0; j < 9; j++) begin
            w = int'($signed(row[j*8 +: 8]));
            if (j < 8) w += (hist[j] == act) ? 1 : -1;
            else       w += act ? 1 : -1;
            if (w > 127)  w = 127;
            if (w < -128) w = -128;
            r[j*8 +: 8] = w[7:0];
        end
        return r;
    endfunction

    task automatic check_outputs();
        chk("enq_ready", 72'(enq_ready), 72'(m_alive && mq.size() < 8 && !m_flush));
        chk("res_ready", 72'(res_ready), 72'(mq.size() > 0 && m_phase == 0));
        chk("flush", 72'(flush), 72'(m_flush));
        if (m_flush) chk("correct_pc", 72'(correct_pc), 72'(m_pc));
        chk("pending_count", 72'(pending_count), 72'(mq.size()));
        chk("wt_rd_en", 72'(wt_rd_en), 72'(m_phase == 1));
        if (m_phase == 1) chk("wt_rd_idx", 72'(wt_rd_idx), 72'(m_tr_idx));
        chk("wt_wr_en", 72'(wt_wr_en), 72'(m_phase == 3));
        if (m_phase == 3) begin
            chk("wt_wr_idx", 72'(wt_wr_idx), 72'(m_tr_idx));
            chk("wt_wr_data", wt_wr_data, m_row);
        end
    endtask

    task automatic cycle(input logic ev, input logic [7:0] ei, input logic [7:0] eh, input logic et,
                         input logic [31:0] etg, input logic [31:0] eft,
                         input logic rv, input logic rt, input logic [31:0] rtg);
        bit   er, rr, efire, rfire, miss, dmiss;
        ent_t h;
        enq_valid = ev; enq_index = ei; enq_hist = eh; enq_taken = et;
        enq_target = etg; enq_fall = eft;
        res_valid = rv; res_taken = rt; res_target = rtg;
        er    = m_alive && mq.size() < 8 && !m_flush;
        rr    = mq.size() > 0 && m_phase == 0;
        efire = ev && er;
        rfire = rv && rr;
        miss  = 0;
        dmiss = 0;
        h     = '{default: '0};
        if (rfire) begin
            h     = mq[0];
            dmiss = (h.taken != rt);
            miss  = dmiss || (h.taken && rt && h.tgt != rtg);
        end
        if (m_phase == 3) begin
            ref_tab[m_tr_idx] = m_row;
            m_phase = 0;
        end else if (m_phase != 0) begin
            m_phase++;
        end
        if (dmiss) begin
            m_phase  = 1;
            m_tr_idx = h.idx;
            m_row    = train_row(ref_tab[h.idx], h.hist, rt);
        end
        m_flush = miss;
        if (miss) m_pc = rt ? rtg : h.ft;
        if (miss) begin
            mq.delete();
        end else begin
            if (rfire) void'(mq.pop_front());
            if (efire) mq.push_back('{ei, eh, et, etg, eft});
        end
        m_alive = 1;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq(input logic [7:0] i, input logic [7:0] hh, input logic t, input logic [31:0] tg, input logic [31:0] f);
        cycle(1, i, hh, t, tg, f, 0, 0, 0);
    endtask

    task automatic res(input logic t, input logic [31:0] tg);
        cycle(0, 0, 0, 0, 0, 0, 1, t, tg);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enq_ready"}, 72'(enq_ready), 72'(0));
        chk({tag, "_res_ready"}, 72'(res_ready), 72'(0));
        chk({tag, "_flush"}, 72'(flush), 72'(0));
        chk({tag, "_correct_pc"}, 72'(correct_pc), 72'(0));
        chk({tag, "_count"}, 72'(pending_count), 72'(0));
        chk({tag, "_rd_en"}, 72'(wt_rd_en), 72'(0));
        chk({tag, "_rd_idx"}, 72'(wt_rd_idx), 72'(0));
        chk({tag, "_wr_en"}, 72'(wt_wr_en), 72'(0));
        chk({tag, "_wr_idx"}, 72'(wt_wr_idx), 72'(0));
        chk({tag, "_wr_data"}, wt_wr_data, 72'(0));
    endtask

    initial begin
        bit [95:0]   r;
        logic        ev, et, rv, rt;
        logic [7:0]  ei, eh;
        logic [31:0] etg, eft, rtg;

        rst_n = 1'b0;
        enq_valid = 0; enq_index = 0; enq_hist = 0; enq_taken = 0;
        enq_target = 0; enq_fall = 0; res_valid = 0; res_taken = 0; res_target = 0;
        wt_rd_data = '0;
        m_alive = 0; m_flush = 0; m_pc = 0; m_phase = 0; m_tr_idx = 0; m_row = 0;
        for (int i = 0; i < 256; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            ref_tab[i] = r[71:0];
        end
        ref_tab[5] = 72'h0;
        ref_tab[9] = 72'h00_000000000000_80_7F;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // Three correct taken predictions retire back to back without flush or training.
        enq(8'd1, 8'h11, 1, 32'h100, 32'h104);
        enq(8'd2, 8'h22, 1, 32'h200, 32'h204);
        enq(8'd3, 8'h33, 1, 32'h300, 32'h304);
        chk("fill3_count", 72'(pending_count), 72'(3));
        res(1, 32'h100);
        res(1, 32'h200);
        res(1, 32'h300);
        chk("drain3_count", 72'(pending_count), 72'(0));
        idle(1);

        // Direction mispredict on a zero row.
        enq(8'd5, 8'h0F, 0, 32'h900, 32'h504);
        res(1, 32'h1000);
        chk("dir_flush", 72'(flush), 72'(1));
        chk("dir_pc", 72'(correct_pc), 72'(32'h1000));
        idle(2);
        chk("dir_wr_en", 72'(wt_wr_en), 72'(1));
        chk("dir_wr_idx", 72'(wt_wr_idx), 72'(5));
        chk("dir_wr_data", wt_wr_data, 72'h01_FF_FF_FF_FF_01_01_01_01);
        idle(1);

        // Saturation at both rails.
        enq(8'd9, 8'h01, 0, 32'h0, 32'h77);
        res(1, 32'h3000);
        idle(2);
        chk("sat_wr_data", wt_wr_data, 72'h01_FFFFFFFFFFFF_80_7F);
        idle(1);

        // Target-only mispredict: flush, no training.
        enq(8'd7, 8'hAA, 1, 32'h2000, 32'h1234);
        res(1, 32'h2040);
        chk("tgt_flush", 72'(flush), 72'(1));
        chk("tgt_pc", 72'(correct_pc), 72'(32'h2040));
        chk("tgt_rd_en", 72'(wt_rd_en), 72'(0));
        chk("tgt_count", 72'(pending_count), 72'(0));
        idle(3);

        // Fill to full, then mispredict with a simultaneous enqueue offer.
        for (int k = 0; k < 8; k++) enq(8'(20 + k), 8'(k * 17), 1, 32'(32'h5000 + k * 16), 32'(32'h6000 + k * 4));
        chk("full_enq_ready", 72'(enq_ready), 72'(0));
        chk("full_count", 72'(pending_count), 72'(8));
        cycle(1, 8'd40, 8'h55, 1, 32'h7000, 32'h7004, 1, 0, 32'h0);
        chk("full_miss_count", 72'(pending_count), 72'(0));
        chk("flush_enq_ready", 72'(enq_ready), 72'(0));
        idle(4);
        enq(8'd41, 8'h12, 1, 32'h8000, 32'h8004);
        enq(8'd42, 8'h34, 0, 32'h8100, 32'h8104);
        cycle(1, 8'd43, 8'h56, 1, 32'h8200, 32'h8204, 1, 1, 32'h8008);
        chk("clear_beats_enq", 72'(pending_count), 72'(0));
        idle(2);

        // Reset asserted during CALC aborts training.
        enq(8'd3, 8'hC3, 0, 32'h0, 32'h9004);
        res(1, 32'h9100);
        idle(1);
        chk("calc_phase_rd_done", 72'(wt_rd_en), 72'(0));
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        mq.delete();
        m_phase = 0; m_flush = 0; m_alive = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ev  = ($urandom_range(0, 3) != 0);
            ei  = 8'($urandom_range(0, 227));
            eh  = 8'($urandom());
            et  = 1'($urandom_range(0, 1));
            etg = 32'h4000 + 32'($urandom_range(0, 3)) * 4;
            eft = $urandom();
            rv  = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
                rt  = mq[0].taken;
                rtg = mq[0].tgt;
            end else begin
                rt  = 1'($urandom_range(0, 1));
                rtg = 32'h4000 + 32'($urandom_range(0, 3)) * 4;
            end
            cycle(ev, ei, eh, et, etg, eft, rv, rt, rtg);
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/b_resolve_train.md
# b_resolve_train

Resolution and training end of the perceptron branch predictor. It holds every B-type prediction the predictor emits in an in-order pending queue and retires each entry against the execute stage's resolved outcome. On a mispredict it raises a one-cycle flush with the correct PC, discards all younger entries, and performs a read-modify-write perceptron update on the weight table. It sits between the predictor front end and the execute/branch unit, and owns the only write port of the weight table.

## Interface
- HIST_LEN, 8, history bits / weights per perceptron
- WEIGHT_W, 8, signed weight width
- TABLE_DEPTH, 228, perceptron rows
- QUEUE_DEPTH, 8, pending-branch entries (power of two)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_enqValid  in  1  predictor offers one B prediction
- i_enqIndex_8  in  8  weight-table row used for the prediction
- i_enqHist_8  in  8  GHR outcome bits at prediction time; bit j pairs with weight j
- i_enqTaken  in  1  predicted direction
- i_enqTarget_32  in  32  taken target
- i_enqFallthrough_32  in  32  not-taken PC
- o_enqReady  out  1  queue not full and o_flush low (combinational)
- i_resValid  in  1  execute resolves oldest outstanding B
- i_resTaken  in  1  actual direction
- i_resTarget_32  in  32  actual taken target
- o_resReady  out  1  queue non-empty and FSM in IDLE
- o_flush  out  1  one-cycle mispredict pulse
- o_correctPC_32  out  32  redirect PC, valid while o_flush
- o_pendingCount_4  out  4  occupied entries, 0..8
- o_wtRdEn / o_wtRdIdx_8  out  1/8  weight-row read request
- i_wtRdData_72  in  72  row, weight j at [j*8+:8], bias at [64+:8]; valid the cycle after o_wtRdEn
- o_wtWrEn / o_wtWrIdx_8 / o_wtWrData_72  out  1/8/72  weight-row write

## Operation
- Enqueue on i_enqValid & o_enqReady; resolve accept on i_resValid & o_resReady; both may occur in one cycle. In that case count is unchanged, unless there is a mispredict.
- Mispredict occurs when the direction differs, or when both are taken and i_resTarget_32 differs from the stored target. Direction-correct entries are only popped; the FSM stays in IDLE, giving 1 resolve/cycle.
- Mispredict at accept edge:
  - The queue is cleared, including a same-cycle enqueue.
  - o_flush=1 for the next cycle, with o_correctPC_32 = resTaken ? i_resTarget_32 : stored fallthrough.
- Training runs only when the direction differs. A target-only mispredict flushes without training.
- FSM states:
  - IDLE: on a direction mispredict accept, go to RD.
  - RD: o_wtRdEn=1 with the stored index; go to CALC.
  - CALC: capture the row. Weight j += (hist_j == actual) ? +1 : -1. Bias += actual ? +1 : -1. All arithmetic is signed 8-bit and saturates at +127/-128. Go to WR.
  - WR: o_wtWrEn=1; go to IDLE.
- Enqueue is allowed during RD/CALC/WR, except in the flush cycle.
- The resolve handshake is unavailable when empty; i_resValid is then ignored.

## Timing
- Reset values: all outputs 0, queue empty, state IDLE.
- Reset mid-training aborts the sequence; no write is issued.
- Accept at edge 0 → o_flush and RD in cycle 1, CALC in cycle 2, WR in cycle 3, o_resReady possible again in cycle 4.
- o_enqReady and o_resReady are combinational from registered state only. There is no combinational path from i_*Valid.
- Pointers wrap modulo QUEUE_DEPTH. Full (8) drops o_enqReady; a same-cycle pop does not free a slot for enqueue.

## Structure
- Package b_pkg holds:
  - HIST_LEN, WEIGHT_W, TABLE_DEPTH, QUEUE_DEPTH
  - the state enum (IDLE, RD, CALC, WR)
  - the pending-entry struct (index, hist, taken, target, fallthrough)
  - a saturating ±1 add function
- Sub-module b_pending_queue: synchronous FIFO with push, pop, clear, count. The top level holds the compare logic and the FSM.

## Test plan
- Enqueue 3 entries, each taken with a matching target; resolve all 3 back-to-back → no flush, count goes 3→0, no weight write.
- Entry (idx 5, hist 0x0F, predicted not-taken); resolve taken with target 0x1000; row weights all 0 → o_flush with PC 0x1000 in cycle 1, write to idx 5 in cycle 3 with weights j0-3=+1, j4-7=-1, bias=+1.
- Weight 127 with hist bit 1 and actual taken → remains 127; weight -128 with a +(-1) update → remains -128.
- Predicted taken 0x2000, resolved taken 0x2040 → flush with PC 0x2040, no o_wtRdEn, queue cleared.
- Fill to 8 → o_enqReady=0; a mispredict resolve with a simultaneous enqueue → count 0 next cycle and the enqueue is dropped.
- Assert i_rst_n low during CALC → all outputs 0 immediately, no o_wtWrEn afterwards.
